// File: rtl/posit_result_buffer_if.sv
// Bus bundle for posit_result_buffer: adder capture side, drain side and credit/status.
// Optional stats signals exist only when POSIT_RESBUF_STATS_EN is defined.
interface posit_result_buffer_if #(
  parameter int unsigned N  = 32,
  parameter int unsigned AW = 4
);
  logic          issue;
  logic [N-1:0]  in_result;
  logic          in_inf;
  logic          in_zero;
  logic          in_done;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_result;
  logic          out_inf;
  logic          out_zero;
  logic [AW:0]   count;
  logic          can_issue;
  logic          err;
`ifdef POSIT_RESBUF_STATS_EN
  logic [15:0]   inf_cnt;
  logic [15:0]   zero_cnt;

  modport master (
    output issue, in_result, in_inf, in_zero, in_done, out_ready,
    input  out_valid, out_result, out_inf, out_zero, count, can_issue, err,
           inf_cnt, zero_cnt
  );

  modport slave (
    input  issue, in_result, in_inf, in_zero, in_done, out_ready,
    output out_valid, out_result, out_inf, out_zero, count, can_issue, err,
           inf_cnt, zero_cnt
  );
`else
  modport master (
    output issue, in_result, in_inf, in_zero, in_done, out_ready,
    input  out_valid, out_result, out_inf, out_zero, count, can_issue, err
  );

  modport slave (
    input  issue, in_result, in_inf, in_zero, in_done, out_ready,
    output out_valid, out_result, out_inf, out_zero, count, can_issue, err
  );
`endif
endinterface

// File: rtl/posit_result_buffer.sv
// Show-ahead result FIFO behind the non-stallable posit adder, with in-flight credit tracking.
// Define POSIT_RESBUF_STATS_EN to add saturating inf/zero result counters.
module posit_result_buffer #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  posit_result_buffer_if.slave bus
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = AW + 2;

  typedef struct packed {
    logic [N-1:0] result;
    logic         inf;
    logic         zero;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          err_q, err_d;
  logic          empty, full, pop, wr, drop, underflow;
  logic [SW-1:0] occupancy;

  // Handshake decode: a pop frees the slot the same cycle, so a full FIFO can still accept.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    pop       = !empty && bus.out_ready;
    wr        = bus.in_done && (!full || pop);
    drop      = bus.in_done && full && !pop;
    underflow = bus.in_done && !bus.issue && (inflight_q == '0);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    err_d      = err_q | drop | underflow;

    if (wr)  wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    if (wr && !pop)      count_d = count_q + CW'(1);
    else if (pop && !wr) count_d = count_q - CW'(1);

    // An unmatched completion with nothing in flight holds at zero rather than wrapping.
    case ({bus.issue, bus.in_done})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   if (!underflow) inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Storage is deliberately left unreset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (rst_n && wr) begin
      mem_q[wr_ptr_q] <= '{result: bus.in_result, inf: bus.in_inf, zero: bus.in_zero};
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign occupancy = SW'(count_q) + SW'(inflight_q);

  assign bus.out_valid  = !empty;
  assign bus.out_result = empty ? '0 : head.result;
  assign bus.out_inf    = !empty && head.inf;
  assign bus.out_zero   = !empty && head.zero;
  assign bus.count      = count_q;
  assign bus.can_issue  = (occupancy < SW'(DEPTH));
  assign bus.err        = err_q;

`ifdef POSIT_RESBUF_STATS_EN
  logic [15:0] inf_cnt_q, inf_cnt_d;
  logic [15:0] zero_cnt_q, zero_cnt_d;

  // Saturating tallies of accepted words carrying each flag.
  always_comb begin
    inf_cnt_d  = inf_cnt_q;
    zero_cnt_d = zero_cnt_q;
    if (wr && bus.in_inf && (inf_cnt_q != 16'hFFFF))   inf_cnt_d  = inf_cnt_q + 16'd1;
    if (wr && bus.in_zero && (zero_cnt_q != 16'hFFFF)) zero_cnt_d = zero_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inf_cnt_q  <= '0;
      zero_cnt_q <= '0;
    end else begin
      inf_cnt_q  <= inf_cnt_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

  assign bus.inf_cnt  = inf_cnt_q;
  assign bus.zero_cnt = zero_cnt_q;
`endif

endmodule
